// File: rtl/enc_pkg.sv
// Shared FSM encoding and default geometry for the iterative Feistel cipher.
// Combinational helpers only; no latency, no flow control.
package enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int HALF_W_DEF = 4;
    localparam int ROUNDS_DEF = 2;

    function automatic int ctr_w(input int rounds);
        return (rounds > 1) ? $clog2(rounds) : 1;
    endfunction

endpackage

// File: rtl/feistel_round.sv
// One Feistel round: f = hi(E(R)^k) + lo(E(R)^k) + k[0]; swaps halves unless final.
// Purely combinational, zero latency, no flow control.
module feistel_round
    import enc_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF
) (
    input  logic [HALF_W-1:0]   l_i,
    input  logic [HALF_W-1:0]   r_i,
    input  logic [2*HALF_W-1:0] key_i,
    input  logic                final_i,
    output logic [HALF_W-1:0]   l_o,
    output logic [HALF_W-1:0]   r_o
);

    logic [2*HALF_W-1:0] r_dbl;
    logic [2*HALF_W-1:0] t;
    logic [HALF_W-1:0]   f;

    always_comb begin
        // Upper half of the doubled-and-shifted word is R rotated left by one.
        r_dbl = {r_i, r_i} << 1;
        t     = {r_i, r_dbl[2*HALF_W-1:HALF_W]} ^ key_i;
        f     = t[2*HALF_W-1:HALF_W] + t[HALF_W-1:0] + HALF_W'(key_i[0]);
        if (final_i) begin
            l_o = l_i ^ f;
            r_o = r_i;
        end else begin
            l_o = r_i;
            r_o = l_i ^ f;
        end
    end

endmodule

// File: rtl/encrypt_iter.sv
// Iterative Feistel encrypt/decrypt, one round per cycle; out_valid ROUNDS cycles after accept.
// Single block in flight: in_ready low in RUN/DONE, result held in DONE until out_ready.
module encrypt_iter
    import enc_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF,
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic [2*HALF_W-1:0] in_key,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_data,
    output logic                busy
);

    localparam int W2 = 2 * HALF_W;
    localparam int CW = ctr_w(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   rnd_q, rnd_d;
    logic [HALF_W-1:0] l_q, l_d, r_q, r_d;
    logic [W2-1:0]   k_q, k_d;
    logic            mode_q, mode_d;
    logic            init_q;

    logic [CW-1:0]   idx;
    logic [2*W2-1:0] k_dbl;
    logic [W2-1:0]   rkey;
    logic            last_rnd;
    logic [HALF_W-1:0] l_nxt, r_nxt;

    // Decrypt walks the same key schedule backwards.
    always_comb begin
        idx      = mode_q ? (LAST - rnd_q) : rnd_q;
        k_dbl    = {k_q, k_q} << (32'(idx) % W2);
        rkey     = k_dbl[2*W2-1:W2];
        last_rnd = (rnd_q == LAST);
    end

    feistel_round #(.HALF_W(HALF_W)) u_round (
        .l_i     (l_q),
        .r_i     (r_q),
        .key_i   (rkey),
        .final_i (last_rnd),
        .l_o     (l_nxt),
        .r_o     (r_nxt)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        l_d     = l_q;
        r_d     = r_q;
        k_d     = k_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && init_q) begin
                    l_d     = in_data[W2-1:HALF_W];
                    r_d     = in_data[HALF_W-1:0];
                    k_d     = in_key;
                    mode_d  = in_mode;
                    rnd_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                l_d = l_nxt;
                r_d = r_nxt;
                if (last_rnd) begin
                    state_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // init_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            l_q     <= l_d;
            r_q     <= r_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            init_q  <= 1'b1;
        end
    end

    assign in_ready  = init_q && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = (state_q == ST_DONE) ? {l_q, r_q} : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_encrypt_iter.sv
// Bench for encrypt_iter: three geometries sharing one stimulus bus, checked against
// an integer Feistel reference model plus the directed vectors.
module tb_encrypt_iter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    int          sel;
    logic        c_valid, c_mode, c_out_ready;
    logic [15:0] c_data, c_key;

    logic       u0_ir, u0_ov, u0_bz;
    logic [7:0] u0_od;
    logic       u1_ir, u1_ov, u1_bz;
    logic [7:0] u1_od;
    logic        u2_ir, u2_ov, u2_bz;
    logic [15:0] u2_od;

    logic        m_ir, m_ov, m_bz;
    logic [15:0] m_data;

    encrypt_iter #(.HALF_W(4), .ROUNDS(1)) u0 (
        .clock(clock), .reset_n(reset_n), .in_valid(c_valid && sel == 0), .in_ready(u0_ir),
        .in_data(c_data[7:0]), .in_key(c_key[7:0]), .in_mode(c_mode),
        .out_valid(u0_ov), .out_ready(c_out_ready), .out_data(u0_od), .busy(u0_bz));

    encrypt_iter #(.HALF_W(4), .ROUNDS(2)) u1 (
        .clock(clock), .reset_n(reset_n), .in_valid(c_valid && sel == 1), .in_ready(u1_ir),
        .in_data(c_data[7:0]), .in_key(c_key[7:0]), .in_mode(c_mode),
        .out_valid(u1_ov), .out_ready(c_out_ready), .out_data(u1_od), .busy(u1_bz));

    encrypt_iter #(.HALF_W(8), .ROUNDS(16)) u2 (
        .clock(clock), .reset_n(reset_n), .in_valid(c_valid && sel == 2), .in_ready(u2_ir),
        .in_data(c_data), .in_key(c_key), .in_mode(c_mode),
        .out_valid(u2_ov), .out_ready(c_out_ready), .out_data(u2_od), .busy(u2_bz));

    always_comb begin
        m_ir   = u0_ir;
        m_ov   = u0_ov;
        m_bz   = u0_bz;
        m_data = {8'h00, u0_od};
        case (sel)
            1: begin m_ir = u1_ir; m_ov = u1_ov; m_bz = u1_bz; m_data = {8'h00, u1_od}; end
            2: begin m_ir = u2_ir; m_ov = u2_ov; m_bz = u2_bz; m_data = u2_od; end
            default: ;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int unsigned rotl(input int unsigned x, input int s, input int w);
        int unsigned m = (32'd1 << w) - 1;
        int sh = s % w;
        if (sh == 0) return x & m;
        return ((x << sh) | (x >> (w - sh))) & m;
    endfunction

    function automatic int unsigned model(input int h, input int rounds, input int unsigned din,
                                          input int unsigned key, input bit mode);
        int unsigned hm = (32'd1 << h) - 1;
        int unsigned l = (din >> h) & hm;
        int unsigned r = din & hm;
        int unsigned k, t, f, tmp;
        for (int i = 0; i < rounds; i++) begin
            k = rotl(key, mode ? rounds - 1 - i : i, 2 * h);
            t = ((r << h) | rotl(r, 1, h)) ^ k;
            f = ((t >> h) + (t & hm) + (k & 1)) & hm;
            if (i == rounds - 1) begin
                l = l ^ f;
            end else begin
                tmp = r;
                r   = l ^ f;
                l   = tmp;
            end
        end
        return (l << h) | r;
    endfunction

    task automatic run_block(input int s, input logic [15:0] d, input logic [15:0] k,
                             input logic m, input int hold,
                             output logic [15:0] res, output int lat);
        int w = 0;
        sel = s;
        while (m_ir !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        check("accept_ready", {31'd0, m_ir}, 32'd1);
        c_data  = d;
        c_key   = k;
        c_mode  = m;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (m_ov !== 1'b1 && lat < 64);
        res = m_data;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_data", {16'd0, m_data}, {16'd0, res});
            check("hold_valid", {31'd0, m_ov}, 32'd1);
        end
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        check("back_idle", {31'd0, m_bz}, 32'd0);
    endtask

    logic [15:0] res, x, k, ct, pt;
    int          lat;

    initial begin
        reset_n     = 1'b0;
        sel         = 0;
        c_valid     = 1'b0;
        c_mode      = 1'b0;
        c_out_ready = 1'b0;
        c_data      = '0;
        c_key       = '0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_in_ready", {31'd0, m_ir}, 32'd0);
            check("rst_out_valid", {31'd0, m_ov}, 32'd0);
            check("rst_busy", {31'd0, m_bz}, 32'd0);
            check("rst_out_data", {16'd0, m_data}, 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("pre_edge_in_ready", {31'd0, m_ir}, 32'd0);
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("post_rst_in_ready", {31'd0, m_ir}, 32'd1);
        end

        // Directed vectors.
        run_block(0, 16'h46, 16'h93, 1'b0, 0, res, lat);
        check("r1_enc_data", {16'd0, res}, 32'hB6);
        check("r1_latency", lat, 1);
        run_block(1, 16'h46, 16'h93, 1'b0, 2, res, lat);
        check("r2_enc_data", {16'd0, res}, 32'hCB);
        check("r2_latency", lat, 2);
        run_block(1, 16'hCB, 16'h93, 1'b1, 0, res, lat);
        check("r2_dec_data", {16'd0, res}, 32'h46);
        check("r2_dec_latency", lat, 2);

        // Backpressure in DONE with a competing input offered.
        sel = 1;
        c_data = 16'h46; c_key = 16'h93; c_mode = 1'b0; c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        tick();
        tick();
        check("bp_valid", {31'd0, m_ov}, 32'd1);
        c_valid = 1'b1;
        c_data  = 16'h12;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data", {16'd0, m_data}, 32'hCB);
            check("bp_in_ready", {31'd0, m_ir}, 32'd0);
            check("bp_busy", {31'd0, m_bz}, 32'd1);
        end
        c_out_ready = 1'b1;
        tick();
        c_out_ready = 1'b0;
        c_valid     = 1'b0;
        check("bp_idle_busy", {31'd0, m_bz}, 32'd0);
        check("bp_idle_data", {16'd0, m_data}, 32'd0);
        check("bp_idle_ready", {31'd0, m_ir}, 32'd1);
        tick();
        check("bp_no_capture", {31'd0, m_bz}, 32'd0);

        // Reset in DONE zeroes the held result immediately.
        sel = 0;
        c_data = 16'h46; c_key = 16'h93; c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        tick();
        check("done_before_rst", {16'd0, m_data}, 32'hB6);
        reset_n = 1'b0;
        #1;
        check("rst_done_data", {16'd0, m_data}, 32'd0);
        check("rst_done_valid", {31'd0, m_ov}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Reset in RUN discards the block.
        sel = 1;
        tick();
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        check("run_busy", {31'd0, m_bz}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_run_busy", {31'd0, m_bz}, 32'd0);
        check("rst_run_ready", {31'd0, m_ir}, 32'd0);
        check("rst_run_data", {16'd0, m_data}, 32'd0);
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_valid", {31'd0, m_ov}, 32'd0);
        end
        run_block(1, 16'h46, 16'h93, 1'b0, 0, res, lat);
        check("post_rst_enc", {16'd0, res}, 32'hCB);

        // Random blocks on the small geometries against the model.
        for (int n = 0; n < 20; n++) begin
            x = 16'($urandom()) & 16'h00FF;
            k = 16'($urandom()) & 16'h00FF;
            c_mode = 1'($urandom());
            run_block(n % 2, x, k, c_mode, $urandom_range(0, 2), res, lat);
            check("small_model", {16'd0, res}, model(4, (n % 2) + 1, x, k, c_mode));
            check("small_latency", lat, (n % 2) + 1);
        end

        // Random round trips on the wide geometry.
        for (int n = 0; n < 1000; n++) begin
            x = 16'($urandom());
            k = 16'($urandom());
            run_block(2, x, k, 1'b0, $urandom_range(0, 3), ct, lat);
            check("wide_enc_model", {16'd0, ct}, model(8, 16, x, k, 1'b0));
            check("wide_enc_latency", lat, 16);
            run_block(2, ct, k, 1'b1, $urandom_range(0, 3), pt, lat);
            check("wide_roundtrip", {16'd0, pt}, {16'd0, x});
            check("wide_dec_latency", lat, 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
